// File: rtl/radio_txrx_sequencer_if.sv
// Bundle of user-side level requests and radio-bridge controls for the
// Tx/Rx power sequencer.
//
// Request protocol: tx_req and rx_req are levels, not valid/ready pulses.
// A request is accepted when the sequencer is in STANDBY and stays in force
// for as long as the level is held. Dropping the level ends the burst or
// receive period. seq_busy reports that a sequence is in flight.
interface radio_txrx_sequencer_if;
    logic       seq_enable;
    logic       tx_req;
    logic       rx_req;
    logic       band_5g;
    logic       ant_sel;
    logic [5:0] tx_gain_target;

    logic       controller_SHDN;
    logic       controller_RxEn;
    logic       controller_RxHP;
    logic       controller_TxEn;
    logic       controller_24PA;
    logic       controller_5PA;
    logic [0:1] controller_ANTSW;
    logic       controller_TxStart;
    logic [0:5] user_Tx_gain;
    logic [0:3] seq_state;
    logic       seq_busy;

    // User logic side: drives requests, observes the radio controls.
    modport master (
        output seq_enable, tx_req, rx_req, band_5g, ant_sel, tx_gain_target,
        input  controller_SHDN, controller_RxEn, controller_RxHP, controller_TxEn,
        input  controller_24PA, controller_5PA, controller_ANTSW, controller_TxStart,
        input  user_Tx_gain, seq_state, seq_busy
    );

    // Sequencer side.
    modport slave (
        input  seq_enable, tx_req, rx_req, band_5g, ant_sel, tx_gain_target,
        output controller_SHDN, controller_RxEn, controller_RxHP, controller_TxEn,
        output controller_24PA, controller_5PA, controller_ANTSW, controller_TxStart,
        output user_Tx_gain, seq_state, seq_busy
    );
endinterface

// File: rtl/radio_txrx_sequencer.sv
// Tx/Rx power sequencer for one radio board. It turns level requests into
// the ordered enable sequence TxEn -> PA -> gain ramp -> TxStart, with the
// reverse order on shutdown, and issues an RxHP pulse on every Rx entry.
// Every output is a flop loaded from the next-state decode.
module radio_txrx_sequencer #(
    parameter logic [15:0] TXEN_TO_PA_DLY   = 16'd100,
    parameter logic [15:0] PA_TO_RAMP_DLY   = 16'd40,
    parameter logic [15:0] GAIN_STEP_CYCLES = 16'd4,
    parameter logic [15:0] TX_OFF_DLY       = 16'd20,
    parameter logic [15:0] RXHP_CYCLES      = 16'd8,
    parameter logic [15:0] RX_OFF_GAP       = 16'd10
) (
    input  logic                         converter_clock_in,
    input  logic                         reset_n,
    radio_txrx_sequencer_if.slave        bus
);

    // A programmed delay of 0 is treated as 1.
    localparam logic [15:0] TXPA_D = (TXEN_TO_PA_DLY   == 16'd0) ? 16'd1 : TXEN_TO_PA_DLY;
    localparam logic [15:0] RAMP_D = (PA_TO_RAMP_DLY   == 16'd0) ? 16'd1 : PA_TO_RAMP_DLY;
    localparam logic [15:0] STEP_D = (GAIN_STEP_CYCLES == 16'd0) ? 16'd1 : GAIN_STEP_CYCLES;
    localparam logic [15:0] OFF_D  = (TX_OFF_DLY       == 16'd0) ? 16'd1 : TX_OFF_DLY;
    localparam logic [15:0] RXHP_D = (RXHP_CYCLES      == 16'd0) ? 16'd1 : RXHP_CYCLES;
    localparam logic [15:0] GAP_D  = (RX_OFF_GAP       == 16'd0) ? 16'd1 : RX_OFF_GAP;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_STANDBY   = 4'd1,
        S_RX_ON     = 4'd2,
        S_RX_OFF    = 4'd3,
        S_TX_EN     = 4'd4,
        S_TX_PA     = 4'd5,
        S_TX_RAMP   = 4'd6,
        S_TX_ACTIVE = 4'd7,
        S_TX_OFF    = 4'd8,
        S_TX_DOWN   = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  gain_q, gain_d;
    logic [5:0]  target_q, target_d;
    logic        band_q, band_d;
    logic [0:1]  antsw_q, antsw_d;
    logic        shdn_q, shdn_d;
    logic        rxen_q, rxen_d;
    logic        rxhp_q, rxhp_d;
    logic        txen_q, txen_d;
    logic        pa24_q, pa24_d;
    logic        pa5_q, pa5_d;
    logic        txstart_q, txstart_d;
    logic        busy_q, busy_d;
    logic        tx_abort;
    logic        go_off;
    logic        pa_on;

    // Next-state, delay counter and datapath, then output decode of the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != 16'd0) ? (cnt_q - 16'd1) : 16'd0;
        gain_d   = gain_q;
        target_d = target_q;
        band_d   = band_q;
        antsw_d  = antsw_q;
        tx_abort = !bus.tx_req || !bus.seq_enable;
        go_off   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.seq_enable) state_d = S_STANDBY;
            end
            S_STANDBY: begin
                if (!bus.seq_enable) begin
                    state_d = S_IDLE;
                end else if (bus.tx_req) begin
                    // Tx wins over a simultaneous Rx request.
                    state_d = S_TX_EN;
                    cnt_d   = TXPA_D;
                    gain_d  = 6'd0;
                    band_d  = bus.band_5g;
                    antsw_d = bus.ant_sel ? 2'b10 : 2'b01;
                end else if (bus.rx_req) begin
                    state_d = S_RX_ON;
                    cnt_d   = RXHP_D;
                    antsw_d = bus.ant_sel ? 2'b10 : 2'b01;
                end
            end
            S_RX_ON: begin
                if (!bus.rx_req || !bus.seq_enable) begin
                    state_d = S_RX_OFF;
                    cnt_d   = GAP_D;
                end
            end
            S_RX_OFF: begin
                if (cnt_q == 16'd1) state_d = bus.seq_enable ? S_STANDBY : S_IDLE;
            end
            S_TX_EN: begin
                if (tx_abort) begin
                    go_off = 1'b1;
                end else if (cnt_q == 16'd1) begin
                    state_d = S_TX_PA;
                    cnt_d   = RAMP_D;
                end
            end
            S_TX_PA: begin
                if (tx_abort) begin
                    go_off = 1'b1;
                end else if (cnt_q == 16'd1) begin
                    state_d  = S_TX_RAMP;
                    cnt_d    = STEP_D;
                    target_d = bus.tx_gain_target;
                end
            end
            S_TX_RAMP: begin
                if (tx_abort) begin
                    go_off = 1'b1;
                end else if (gain_q == target_q) begin
                    // A zero target still waits out one full step period.
                    if (target_q != 6'd0 || cnt_q == 16'd1) state_d = S_TX_ACTIVE;
                end else if (cnt_q == 16'd1) begin
                    gain_d = gain_q + 6'd1;
                    cnt_d  = STEP_D;
                end
            end
            S_TX_ACTIVE: begin
                if (tx_abort) go_off = 1'b1;
            end
            S_TX_OFF: begin
                if (cnt_q == 16'd1) state_d = S_TX_DOWN;
            end
            S_TX_DOWN: begin
                state_d = bus.seq_enable ? S_STANDBY : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shutdown always walks through TX_OFF and TX_DOWN.
        if (go_off) begin
            state_d = S_TX_OFF;
            cnt_d   = OFF_D;
            gain_d  = 6'd0;
        end

        pa_on     = (state_d == S_TX_PA) || (state_d == S_TX_RAMP) || (state_d == S_TX_ACTIVE);
        shdn_d    = (state_d != S_IDLE);
        rxen_d    = (state_d == S_RX_ON);
        rxhp_d    = (state_d == S_RX_ON) && ((state_q != S_RX_ON) || (cnt_q > 16'd1));
        txen_d    = pa_on || (state_d == S_TX_EN) || (state_d == S_TX_OFF);
        pa24_d    = pa_on && !band_d;
        pa5_d     = pa_on && band_d;
        txstart_d = (state_d == S_TX_ACTIVE) && (state_q != S_TX_ACTIVE);
        busy_d    = (state_d != S_IDLE) && (state_d != S_STANDBY);
    end

    // State, datapath and registered outputs; reset clears everything at once.
    always_ff @(posedge converter_clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            gain_q    <= 6'd0;
            target_q  <= 6'd0;
            band_q    <= 1'b0;
            antsw_q   <= 2'b01;
            shdn_q    <= 1'b0;
            rxen_q    <= 1'b0;
            rxhp_q    <= 1'b0;
            txen_q    <= 1'b0;
            pa24_q    <= 1'b0;
            pa5_q     <= 1'b0;
            txstart_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gain_q    <= gain_d;
            target_q  <= target_d;
            band_q    <= band_d;
            antsw_q   <= antsw_d;
            shdn_q    <= shdn_d;
            rxen_q    <= rxen_d;
            rxhp_q    <= rxhp_d;
            txen_q    <= txen_d;
            pa24_q    <= pa24_d;
            pa5_q     <= pa5_d;
            txstart_q <= txstart_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.controller_SHDN    = shdn_q;
    assign bus.controller_RxEn    = rxen_q;
    assign bus.controller_RxHP    = rxhp_q;
    assign bus.controller_TxEn    = txen_q;
    assign bus.controller_24PA    = pa24_q;
    assign bus.controller_5PA     = pa5_q;
    assign bus.controller_ANTSW   = antsw_q;
    assign bus.controller_TxStart = txstart_q;
    assign bus.user_Tx_gain       = gain_q;
    assign bus.seq_state          = state_q;
    assign bus.seq_busy           = busy_q;

endmodule

// File: tb/tb_radio_txrx_sequencer.sv
// Bench for radio_txrx_sequencer: directed scenarios with randomized gain,
// band, antenna and drop points, compared cycle by cycle against a timing
// model computed from the sequencing rules.
module tb_radio_txrx_sequencer;

    localparam int D   = 100;  // TxEn -> PA
    localparam int P   = 40;   // PA -> ramp start
    localparam int G   = 4;    // cycles per gain step
    localparam int OFF = 20;   // PA off -> TxEn fall
    localparam int H   = 8;    // RxHP width
    localparam int GAP = 10;   // Rx off gap

    typedef struct packed {
        logic [3:0] st;
        logic       shdn;
        logic       rxen;
        logic       rxhp;
        logic       txen;
        logic       pa24;
        logic       pa5;
        logic [1:0] antsw;
        logic       txstart;
        logic       busy;
        logic [5:0] gain;
    } outs_t;

    logic converter_clock_in;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    radio_txrx_sequencer_if bus();

    radio_txrx_sequencer dut (
        .converter_clock_in (converter_clock_in),
        .reset_n            (reset_n),
        .bus                (bus)
    );

    // Clock
    initial begin
        converter_clock_in = 1'b0;
        forever #5 converter_clock_in = ~converter_clock_in;
    end

    // Safety net against a run that never ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // RxEn and TxEn must never be high together.
    always @(negedge converter_clock_in) begin
        if (reset_n) begin
            tests_run++;
            assert (!(bus.controller_RxEn === 1'b1 && bus.controller_TxEn === 1'b1)) else begin
                tests_failed++;
                $error("FAIL rx_tx_exclusive: observed RxEn=%b TxEn=%b, required not both 1",
                       bus.controller_RxEn, bus.controller_TxEn);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [1:0] ant_code(input bit ant);
        return ant ? 2'b10 : 2'b01;
    endfunction

    function automatic int act_k(input int t);
        return (t == 0) ? (D + P + 1 + G) : (D + P + 1 + t * G + 1);
    endfunction

    function automatic outs_t m_reset();
        outs_t o = '0;
        o.antsw = 2'b01;
        return o;
    endfunction

    function automatic outs_t m_standby(input logic [1:0] aw);
        outs_t o = '0;
        o.st = 4'd1; o.shdn = 1'b1; o.antsw = aw;
        return o;
    endfunction

    // Outputs k cycles after tx_req is raised from STANDBY, tx_req still held.
    function automatic outs_t m_tx(input int k, input int t, input bit band, input logic [1:0] aw);
        outs_t o = '0;
        int    g;
        o.shdn = 1'b1; o.busy = 1'b1; o.txen = 1'b1; o.antsw = aw;
        if (k <= D) begin
            o.st = 4'd4;
        end else begin
            o.pa24 = !band;
            o.pa5  = band;
            if (k <= D + P) begin
                o.st = 4'd5;
            end else if (k < act_k(t)) begin
                o.st = 4'd6;
                g = (k - (D + 1) - P) / G;
                o.gain = 6'((g > t) ? t : g);
            end else begin
                o.st = 4'd7;
                o.gain = 6'(t);
                o.txstart = (k == act_k(t));
            end
        end
        return o;
    endfunction

    // Outputs j cycles after the Tx sequence was told to stop.
    function automatic outs_t m_txoff(input int j, input bit se, input logic [1:0] aw);
        outs_t o = '0;
        o.antsw = aw;
        if (j <= OFF) begin
            o.st = 4'd8; o.shdn = 1'b1; o.txen = 1'b1; o.busy = 1'b1;
        end else if (j == OFF + 1) begin
            o.st = 4'd9; o.shdn = 1'b1; o.busy = 1'b1;
        end else if (se) begin
            o = m_standby(aw);
        end
        return o;
    endfunction

    function automatic outs_t m_rx(input int k, input logic [1:0] aw);
        outs_t o = '0;
        o.st = 4'd2; o.shdn = 1'b1; o.rxen = 1'b1; o.busy = 1'b1; o.antsw = aw;
        o.rxhp = (k <= H);
        return o;
    endfunction

    function automatic outs_t m_rxoff(input int j, input logic [1:0] aw);
        outs_t o = '0;
        if (j <= GAP) begin
            o.st = 4'd3; o.shdn = 1'b1; o.busy = 1'b1; o.antsw = aw;
        end else begin
            o = m_standby(aw);
        end
        return o;
    endfunction

    // ---------------- driver / checker tasks ----------------
    function automatic outs_t sample_dut();
        outs_t o;
        o.st      = bus.seq_state;
        o.shdn    = bus.controller_SHDN;
        o.rxen    = bus.controller_RxEn;
        o.rxhp    = bus.controller_RxHP;
        o.txen    = bus.controller_TxEn;
        o.pa24    = bus.controller_24PA;
        o.pa5     = bus.controller_5PA;
        o.antsw   = bus.controller_ANTSW;
        o.txstart = bus.controller_TxStart;
        o.busy    = bus.seq_busy;
        o.gain    = bus.user_Tx_gain;
        return o;
    endfunction

    task automatic check_outs(input string tag, input outs_t exp);
        outs_t obs;
        obs = sample_dut();
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h (st/shdn/rxen/rxhp/txen/24pa/5pa/antsw/txstart/busy/gain)",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge converter_clock_in);
        #1;
    endtask

    // mode 0: drop tx_req, 1: drop seq_enable, 2: async reset.
    task automatic run_tx(input int t, input bit band, input bit ant, input int drop_k,
                          input int mode, input bit with_rx);
        logic [1:0] aw;
        aw = ant_code(ant);
        bus.band_5g        = band;
        bus.ant_sel        = ant;
        bus.tx_gain_target = 6'(t) ^ 6'h3F;
        bus.tx_req         = 1'b1;
        if (with_rx) bus.rx_req = 1'b1;
        for (int k = 1; k <= drop_k; k++) begin
            step();
            check_outs($sformatf("tx t=%0d k=%0d", t, k), m_tx(k, t, band, aw));
            if (k == 1) begin
                bus.band_5g = ~band;
                bus.ant_sel = ~ant;
            end
            if (k == D + P) bus.tx_gain_target = 6'(t);
            if (k == D + P + 1) bus.tx_gain_target = 6'(t) ^ 6'h2A;
        end
        if (mode == 2) begin
            #2 reset_n = 1'b0;
            #1 check_outs("async reset", m_reset());
            bus.tx_req = 1'b0;
            bus.rx_req = 1'b0;
            step();
            check_outs("held reset", m_reset());
            reset_n = 1'b1;
            step();
            check_outs("standby after reset", m_standby(2'b01));
        end else if (mode == 1) begin
            bus.seq_enable = 1'b0;
            for (int j = 1; j <= OFF + 2; j++) begin
                step();
                check_outs($sformatf("tx off se j=%0d", j), m_txoff(j, 1'b0, aw));
            end
            bus.tx_req     = 1'b0;
            bus.rx_req     = 1'b0;
            bus.seq_enable = 1'b1;
            step();
            check_outs("standby after idle", m_standby(aw));
        end else begin
            bus.tx_req = 1'b0;
            bus.rx_req = 1'b0;
            for (int j = 1; j <= OFF + 2; j++) begin
                step();
                check_outs($sformatf("tx off j=%0d", j), m_txoff(j, 1'b1, aw));
            end
        end
    endtask

    // tx_early: raise tx_req inside RX_ON (ignored there), else inside the gap.
    task automatic run_rx(input bit ant, input int hold, input bit tx_early);
        logic [1:0] aw;
        int         gap_at;
        aw     = ant_code(ant);
        gap_at = $urandom_range(1, GAP - 1);
        bus.ant_sel = ant;
        bus.rx_req  = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            step();
            check_outs($sformatf("rx k=%0d", k), m_rx(k, aw));
            if (k == 1) bus.ant_sel = ~ant;
            if (k == 2 && tx_early) bus.tx_req = 1'b1;
        end
        bus.rx_req = 1'b0;
        for (int j = 1; j <= GAP + 1; j++) begin
            step();
            check_outs($sformatf("rx off j=%0d", j), m_rxoff(j, aw));
            if (j == gap_at) bus.tx_req = 1'b1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  t;
        bit  band;
        bit  ant;
        int  mode;
        tests_run          = 0;
        tests_failed       = 0;
        reset_n            = 1'b1;
        bus.seq_enable     = 1'b0;
        bus.tx_req         = 1'b0;
        bus.rx_req         = 1'b0;
        bus.band_5g        = 1'b0;
        bus.ant_sel        = 1'b0;
        bus.tx_gain_target = 6'd0;
        #2 reset_n = 1'b0;
        #1 check_outs("reset values", m_reset());
        repeat (3) step();
        check_outs("reset held", m_reset());

        reset_n = 1'b1;
        step();
        check_outs("idle without enable", m_reset());
        bus.seq_enable = 1'b1;
        step();
        check_outs("standby entry", m_standby(2'b01));

        // Default burst: 2.4 GHz, target 20, antenna A.
        run_tx(20, 1'b0, 1'b0, act_k(20) + 3, 0, 1'b0);

        // Rx on antenna B, then Tx requested during the gap.
        run_rx(1'b1, 12, 1'b0);
        run_tx(int'($urandom_range(1, 63)), 1'($urandom_range(0, 1)), 1'b0, 5, 0, 1'b0);

        // Rx with a Tx request raised while RX_ON (ignored until STANDBY).
        run_rx(1'($urandom_range(0, 1)), int'($urandom_range(10, 20)), 1'b1);
        run_tx(int'($urandom_range(1, 63)), 1'b1, 1'($urandom_range(0, 1)), D + 3, 0, 1'b0);

        // tx_req and rx_req together: Tx wins, RxEn stays low.
        t = $urandom_range(1, 40);
        run_tx(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), act_k(t) + 2, 0, 1'b1);

        // Abort during TX_PA.
        run_tx(30, 1'b1, 1'b1, int'($urandom_range(D + 1, D + P - 1)), 0, 1'b0);

        // Zero target.
        run_tx(0, 1'($urandom_range(0, 1)), 1'b0, act_k(0) + 2, 0, 1'b0);

        // Random bursts with random drop points and drop causes.
        for (int n = 0; n < 3; n++) begin
            t    = $urandom_range(0, 63);
            band = 1'($urandom_range(0, 1));
            ant  = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 1);
            run_tx(t, band, ant, int'($urandom_range(1, act_k(t) + 4)), mode, 1'b0);
        end

        // seq_enable drop during the ramp: full off sequence, then IDLE.
        t = $urandom_range(5, 63);
        run_tx(t, 1'b0, 1'b1, int'($urandom_range(D + P + 2, act_k(t) - 2)), 1, 1'b0);

        // Async reset while TX_ACTIVE.
        t = $urandom_range(1, 63);
        run_tx(t, 1'b1, 1'b1, act_k(t) + 2, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
